// File: rtl/player_shot.sv
// Player laser shot controller: launches one upward shot from the player
// cannon on a fire press, steps it up once per frame, ends it on an invader
// hit or at the top of the playfield, shows an explosion, then holds off
// further shots for a short cooldown.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no shot; waiting for a latched fire press and a frame tick
// FLIGHT    | shot moving up one step per frame; hit/top checks active
// EXPLODE   | explosion sprite shown at the last shot position
// COOLDOWN  | explosion over; fire presses ignored until it expires
module player_shot #(
    parameter int PLAYER_Y        = 432,
    parameter int PLAYER_W        = 32,
    parameter int SHOT_HEIGHT     = 16,
    parameter int SHOT_STEP       = 8,
    parameter int TOP_Y           = 32,
    parameter int EXPLODE_FRAMES  = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic       invader_hit,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       shot_active,
    output logic       exploding,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLIGHT   = 2'd1;
    localparam logic [1:0] ST_EXPLODE  = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    localparam logic [9:0] HALF_W     = 10'(PLAYER_W / 2);
    localparam logic [9:0] LAUNCH_Y   = 10'(PLAYER_Y - SHOT_HEIGHT);
    localparam logic [9:0] STEP_Y     = 10'(SHOT_STEP);
    localparam logic [9:0] TOP_LIMIT  = 10'(TOP_Y);
    // Below this y another full step would cross the top (or wrap below 0).
    localparam logic [9:0] MISS_LIMIT = 10'(TOP_Y + SHOT_STEP);
    localparam logic [3:0] EXP_LAST   = 4'(EXPLODE_FRAMES - 1);
    localparam logic [3:0] COOL_LAST  = 4'(COOLDOWN_FRAMES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       fire_d;
    logic       fire_req;
    logic       fire_edge;
    logic       launch;

    assign fire_edge = fire & ~fire_d;
    assign launch    = (state == ST_IDLE) && frame && fire_req;

    // Fire press latch: only a fresh rising edge seen in IDLE arms a launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_d   <= 1'b0;
            fire_req <= 1'b0;
        end else begin
            fire_d <= fire;
            if (state != ST_IDLE) begin
                fire_req <= 1'b0;
            end else if (launch) begin
                fire_req <= 1'b0;
            end else if (fire_edge) begin
                fire_req <= 1'b1;
            end
        end
    end

    // Shot state machine with registered position, flags and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            shot_x      <= 10'd0;
            shot_y      <= 10'd0;
            shot_active <= 1'b0;
            exploding   <= 1'b0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        shot_x      <= player_x + HALF_W;
                        shot_y      <= LAUNCH_Y;
                        shot_active <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    // A hit wins over movement so the explosion lands where the hit was seen.
                    if (invader_hit) begin
                        shot_active <= 1'b0;
                        exploding   <= 1'b1;
                        hit_pulse   <= 1'b1;
                        cnt         <= 4'd0;
                        state       <= ST_EXPLODE;
                    end else if (frame) begin
                        if (shot_y < MISS_LIMIT) begin
                            shot_y      <= TOP_LIMIT;
                            shot_active <= 1'b0;
                            exploding   <= 1'b1;
                            miss_pulse  <= 1'b1;
                            cnt         <= 4'd0;
                            state       <= ST_EXPLODE;
                        end else begin
                            shot_y <= shot_y - STEP_Y;
                        end
                    end
                end
                ST_EXPLODE: begin
                    if (frame) begin
                        if (cnt == EXP_LAST) begin
                            exploding <= 1'b0;
                            cnt       <= 4'd0;
                            state     <= ST_COOLDOWN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (frame) begin
                        if (cnt == COOL_LAST) begin
                            cnt   <= 4'd0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_shot.sv
// Directed bench for player_shot: a vector table for launch/motion/hit,
// followed by hand-written sequences for top miss, lockout and async reset.
module tb_player_shot;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       fire;
    logic [9:0] player_x;
    logic       invader_hit;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic       shot_active;
    logic       exploding;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       busy;

    int checks;
    int failures;

    player_shot dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .fire        (fire),
        .player_x    (player_x),
        .invader_hit (invader_hit),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_active (shot_active),
        .exploding   (exploding),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       fire;
        logic       frame;
        logic [9:0] px;
        logic       hit;
        logic       e_active;
        logic [9:0] e_x;
        logic [9:0] e_y;
        logic       e_expl;
        logic       e_hit;
        logic       e_miss;
        logic       e_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic a, input logic [9:0] x,
                         input logic [9:0] y, input logic e, input logic h,
                         input logic m, input logic b);
        logic [24:0] act;
        logic [24:0] exp;
        act = {shot_active, shot_x, shot_y, exploding, hit_pulse, miss_pulse, busy};
        exp = {a, x, y, e, h, m, b};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got active=%0b x=%0d y=%0d expl=%0b hit=%0b miss=%0b busy=%0b, want active=%0b x=%0d y=%0d expl=%0b hit=%0b miss=%0b busy=%0b",
                     name, shot_active, shot_x, shot_y, exploding, hit_pulse, miss_pulse, busy,
                     a, x, y, e, h, m, b);
        end
    endtask

    // Drive one clk worth of inputs, then sample just after the rising edge.
    task automatic step(input logic f, input logic fr, input logic [9:0] px, input logic h);
        @(negedge clk);
        fire        = f;
        frame       = fr;
        player_x    = px;
        invader_hit = h;
        @(posedge clk);
        #1;
    endtask

    // From EXPLODE with cnt=0: 8 frames of explosion, then 4 frames of cooldown.
    task automatic expl_cool(input string name, input logic f, input logic [9:0] px,
                             input logic [9:0] x, input logic [9:0] y);
        for (int i = 1; i <= 8; i++) begin
            step(f, 1'b1, px, 1'b0);
            check({name, "_expl"}, 1'b0, x, y, (i < 8), 1'b0, 1'b0, 1'b1);
        end
        for (int i = 1; i <= 4; i++) begin
            step(f, 1'b1, px, 1'b0);
            check({name, "_cool"}, 1'b0, x, y, 1'b0, 1'b0, 1'b0, (i < 4));
        end
    endtask

    // Press fire (edge) and deliver a frame; shot must appear at px+16, 416.
    task automatic launch_shot(input string name, input logic [9:0] px);
        step(1'b0, 1'b0, px, 1'b0);
        step(1'b1, 1'b0, px, 1'b0);
        step(1'b1, 1'b1, px, 1'b0);
        check(name, 1'b1, px + 10'd16, 10'd416, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        fire        = 1'b0;
        frame       = 1'b0;
        player_x    = 10'd0;
        invader_hit = 1'b0;

        vecs[0] = '{"idle",        0, 0, 10'd100, 0, 0, 10'd0,   10'd0,   0, 0, 0, 0};
        vecs[1] = '{"press",       1, 0, 10'd100, 0, 0, 10'd0,   10'd0,   0, 0, 0, 0};
        vecs[2] = '{"launch",      1, 1, 10'd100, 0, 1, 10'd116, 10'd416, 0, 0, 0, 1};
        vecs[3] = '{"no_frame",    1, 0, 10'd100, 0, 1, 10'd116, 10'd416, 0, 0, 0, 1};
        vecs[4] = '{"step1",       1, 1, 10'd100, 0, 1, 10'd116, 10'd408, 0, 0, 0, 1};
        vecs[5] = '{"step2_move",  1, 1, 10'd200, 0, 1, 10'd116, 10'd400, 0, 0, 0, 1};
        vecs[6] = '{"hold",        0, 0, 10'd200, 0, 1, 10'd116, 10'd400, 0, 0, 0, 1};
        vecs[7] = '{"hit_noframe", 0, 0, 10'd200, 1, 0, 10'd116, 10'd400, 1, 1, 0, 1};
        vecs[8] = '{"hit_end",     0, 0, 10'd200, 0, 0, 10'd116, 10'd400, 1, 0, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table: launch, stepping, player motion, hit without a frame.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].fire, vecs[i].frame, vecs[i].px, vecs[i].hit);
            check(vecs[i].name, vecs[i].e_active, vecs[i].e_x, vecs[i].e_y,
                  vecs[i].e_expl, vecs[i].e_hit, vecs[i].e_miss, vecs[i].e_busy);
        end
        expl_cool("hit1", 1'b0, 10'd200, 10'd116, 10'd400);

        // Hit coinciding with a frame: no step, launch uses the new player_x.
        launch_shot("launch2", 10'd200);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 10'd200, 1'b0);
        check("ten_frames", 1'b1, 10'd216, 10'd336, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 10'd200, 1'b1);
        check("hit_frame", 1'b0, 10'd216, 10'd336, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 10'd200, 1'b1);
        check("hit_once", 1'b0, 10'd216, 10'd336, 1'b1, 1'b0, 1'b0, 1'b1);
        expl_cool("hit2", 1'b0, 10'd200, 10'd216, 10'd336);

        // Edge and frame in the same clk: launch waits for the next frame.
        step(1'b0, 1'b0, 10'd100, 1'b0);
        step(1'b1, 1'b1, 10'd100, 1'b0);
        check("same_clk", 1'b0, 10'd216, 10'd336, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 10'd100, 1'b0);
        check("next_frame", 1'b1, 10'd116, 10'd416, 1'b0, 1'b0, 1'b0, 1'b1);

        // Top miss: 48 steps to y=32, the 49th frame ends the shot.
        for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 10'd100, 1'b0);
        check("at_top", 1'b1, 10'd116, 10'd32, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 10'd100, 1'b0);
        check("miss", 1'b0, 10'd116, 10'd32, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 10'd100, 1'b0);
        check("miss_once", 1'b0, 10'd116, 10'd32, 1'b1, 1'b0, 1'b0, 1'b1);
        expl_cool("miss", 1'b0, 10'd100, 10'd116, 10'd32);

        // Lockout: fire held throughout, re-pressed during cooldown.
        launch_shot("launch3", 10'd100);
        step(1'b1, 1'b1, 10'd100, 1'b0);
        step(1'b1, 1'b1, 10'd100, 1'b0);
        step(1'b1, 1'b0, 10'd100, 1'b1);
        check("lock_hit", 1'b0, 10'd116, 10'd400, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 10'd100, 1'b0);
        check("lock_cool", 1'b0, 10'd116, 10'd400, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 10'd100, 1'b0);
        step(1'b1, 1'b0, 10'd100, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 10'd100, 1'b0);
        check("lock_idle", 1'b0, 10'd116, 10'd400, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 10'd100, 1'b0);
            check("lock_held", 1'b0, 10'd116, 10'd400, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        launch_shot("relaunch", 10'd150);

        // Async reset between clock edges mid-flight.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'd150, 1'b0);
        check("pre_rst", 1'b1, 10'd166, 10'd392, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 10'd150, 1'b0);
            check("post_rst", 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        launch_shot("rst_launch", 10'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_shot.md
Name: player_shot

Overview:
- Controls the player's single upward laser shot. It is the counterpart of the invaders' downward missile logic.
- Turns the fire button into a shot launched from the player cannon and moves it up one step per frame.
- Ends the shot on an invader hit or at the top of the playfield, shows a short explosion, then enforces a cooldown before the next shot.
- Sits between input debouncing, the collision checker and the renderer.

Parameters:
- PLAYER_Y, 432: top y of the player cannon sprite (pixels).
- PLAYER_W, 32: scaled player sprite width (pixels).
- SHOT_HEIGHT, 16: scaled shot sprite height (pixels).
- SHOT_STEP, 8: pixels moved up per frame.
- TOP_Y, 32: uppermost y the shot may occupy; the score bar is above it.
- EXPLODE_FRAMES, 8: frames the explosion sprite is shown; range 1..15.
- COOLDOWN_FRAMES, 4: frames after the explosion during which fire is ignored; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- frame  in  1  one-clk pulse per video frame.
- fire  in  1  debounced fire button, level.
- player_x  in  10  current player cannon left x.
- invader_hit  in  1  collision checker: shot overlaps a live invader. Meaningful only while shot_active.
- shot_x  out  10  shot left x.
- shot_y  out  10  shot top y.
- shot_active  out  1  shot in flight; renderer draws the shot and collision checker uses it.
- exploding  out  1  explosion sprite shown at shot_x/shot_y.
- hit_pulse  out  1  one-clk pulse on invader hit; drives score and invader kill.
- miss_pulse  out  1  one-clk pulse when the shot reaches the top.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: clk and rst are as decided above. On rst, state=IDLE, fire_d=0, fire_req=0, cnt=0, and all outputs go to 0. Reset mid-flight or mid-explosion aborts immediately; there is no residual pulse.
- Fire edge detect:
  - fire_d registered every clk.
  - A rising edge (fire & ~fire_d) sets fire_req, but only while state=IDLE.
  - fire_req is cleared whenever state≠IDLE and when it is consumed.
  - Holding fire does not auto-repeat; a new press is required.
- State register is 2 bits: IDLE, FLIGHT, EXPLODE, COOLDOWN. cnt is a 4-bit frame counter.
- IDLE:
  - On frame with fire_req=1: shot_x <= player_x + PLAYER_W/2, shot_y <= PLAYER_Y - SHOT_HEIGHT, shot_active <= 1, state <= FLIGHT, fire_req <= 0.
  - Launch latency: the shot appears on the clk after the first frame pulse following the press.
  - If the edge and frame arrive in the same clk, the launch occurs on the next frame.
- FLIGHT:
  - invader_hit=1 (any clk, including a frame clk): shot_active <= 0, exploding <= 1, hit_pulse <= 1 for exactly one clk, cnt <= 0, state <= EXPLODE. shot_y is frozen.
  - A hit takes priority over movement in the same clk.
  - Else on frame, if shot_y < TOP_Y + SHOT_STEP: shot_y <= TOP_Y, shot_active <= 0, exploding <= 1, miss_pulse <= 1 for one clk, cnt <= 0, state <= EXPLODE.
  - Else on frame: shot_y <= shot_y - SHOT_STEP.
  - The unsigned comparison prevents wrap below 0. shot_x is constant during flight; player motion does not drag the shot.
- EXPLODE:
  - On each frame, cnt increments.
  - When cnt == EXPLODE_FRAMES-1 at a frame: exploding <= 0, cnt <= 0, state <= COOLDOWN.
  - invader_hit is ignored.
- COOLDOWN:
  - On each frame, cnt increments.
  - When cnt == COOLDOWN_FRAMES-1 at a frame: state <= IDLE.
  - Fire edges are ignored.
- Pulses: hit_pulse and miss_pulse are never both 1 in the same clk and never last more than one clk.
- Outputs: all outputs are registered. shot_x/shot_y hold their last value in IDLE and COOLDOWN.
- Arithmetic: all arithmetic is 10-bit unsigned. Parameters must satisfy PLAYER_Y - SHOT_HEIGHT >= TOP_Y.

Test Plan:
- Launch: rst, then player_x=100 and pulse fire, then frame → shot_active=1, shot_x=116, shot_y=416. Each further frame subtracts 8 (408, 400, …).
- Top miss: after launch, run frames with no hit.
  - After 48 frames, shot_y=32.
  - The 49th frame gives miss_pulse=1 for one clk, shot_y=32, exploding=1.
  - exploding drops after 8 frames, busy drops 4 frames later.
- Hit: launch, 10 frames (shot_y=336), assert invader_hit on the same clk as a frame → hit_pulse one clk, shot_y stays 336 (no step), shot_active=0, exploding=1 for 8 frames.
- Lockout: hold fire high through flight and explosion, and press again during COOLDOWN → no new launch. In IDLE with fire held high, no launch until fire is released and re-pressed.
- Player motion: change player_x from 100 to 200 mid-flight → shot_x stays 116. The next launch uses 216.
- Async reset: assert rst mid-FLIGHT between clk edges → all outputs 0 immediately, state IDLE. No pulse after release; a new press launches normally.
